// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: stage masks, FSM states,
// exception codes and the core-wide stop/reset/zero constants.
package pipe_stall_ctrl_pkg;

    localparam int unsigned STALL_W = 6;
    localparam int unsigned WORD_W  = 32;

    localparam logic                  STOP       = 1'b1;
    localparam logic                  NO_STOP    = 1'b0;
    localparam logic                  RST_ENABLE = 1'b1;
    localparam logic [WORD_W-1:0]     ZERO_WORD  = 32'h0000_0000;

    // Nested hold masks: each deeper stage also holds every stage in front of it
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_MC   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    localparam logic [WORD_W-1:0] EXC_NONE = 32'h0000_0000;
    localparam logic [WORD_W-1:0] EXC_ERET = 32'h0000_000e;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MC_BUSY = 1'b1
    } mc_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_mc_seq_counter.sv
// Multi-cycle EX sequencer: FSM plus down-counter for MULT/DIV, producing the
// EX stall request, busy flag and a one-cycle done strobe.
module mc_seq_counter
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic mc_start,
    input  logic mc_is_div,
    input  logic abort,
    output logic mc_busy,
    output logic mc_done,
    output logic stall_mc
);

    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    mc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter and outputs; an exception aborts any op in flight
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mc_busy  = 1'b0;
        mc_done  = 1'b0;
        stall_mc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mc_start) begin
                    stall_mc = 1'b1;
                    state_d  = ST_MC_BUSY;
                    cnt_d    = mc_is_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            ST_MC_BUSY: begin
                mc_busy = 1'b1;
                if (cnt_q == '0) begin
                    mc_done = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    stall_mc = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall/flush controller for the 5-stage core.
// Optional STALL_PERF_EN adds saturating stall-cycle and multi-cycle-op counters.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned CNT_W      = 6,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int unsigned PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_mem,
    input  logic              mc_start,
    input  logic              mc_is_div,
    input  logic [31:0]       excepttype,
    input  logic [31:0]       cp0_epc,
    output logic [5:0]        stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              mc_busy,
    output logic              mc_done,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_mc_ops
);

    logic exc_hit;
    logic stall_mc;

    assign exc_hit = (excepttype != EXC_NONE);

    mc_seq_counter #(
        .DIV_CYCLES (DIV_CYCLES),
        .MUL_CYCLES (MUL_CYCLES),
        .CNT_W      (CNT_W)
    ) u_mc_seq (
        .clk       (clk),
        .rst       (rst),
        .mc_start  (mc_start),
        .mc_is_div (mc_is_div),
        .abort     (exc_hit),
        .mc_busy   (mc_busy),
        .mc_done   (mc_done),
        .stall_mc  (stall_mc)
    );

    // Stall mask merge with exception override; the nested masks let the deepest request win
    always_comb begin
        stall  = STALL_NONE;
        flush  = NO_STOP;
        new_pc = ZERO_WORD;

        if (exc_hit) begin
            flush  = STOP;
            new_pc = (excepttype == EXC_ERET) ? cp0_epc : EXC_VECTOR;
        end else begin
            if (stallreq_if)  stall = stall | STALL_IF;
            if (stallreq_id)  stall = stall | STALL_ID;
            if (stall_mc)     stall = stall | STALL_MC;
            if (stallreq_mem) stall = stall | STALL_MEM;
        end
    end

`ifdef STALL_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] mc_ops_q;

    // Saturating event counters, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            stall_cnt_q <= '0;
            mc_ops_q    <= '0;
        end else begin
            if ((stall[0] == STOP) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            if (mc_done && (mc_ops_q != '1))
                mc_ops_q <= mc_ops_q + PERF_W'(1);
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_mc_ops       = mc_ops_q;
`else
    assign perf_stall_cycles = '0;
    assign perf_mc_ops       = '0;
`endif

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS32 core. Drives the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Collects stall requests from the IF, ID and MEM stages.
- Sequences multi-cycle EX operations (MULT/DIV) with an internal FSM and down-counter.
- Issues pipeline flush and redirect PC on exceptions.

Parameters:
- DIV_CYCLES, 32, total EX stall cycles for a divide (must be >= 2)
- MUL_CYCLES, 4, total EX stall cycles for a multiply (must be >= 2)
- CNT_W, 6, width of the multi-cycle down-counter (must hold max(DIV_CYCLES, MUL_CYCLES) - 1)
- EXC_VECTOR, 32'h00000020, redirect PC for all non-ERET exceptions
- PERF_W, 32, width of the performance counters

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous reset, active-high
- stallreq_if  in  1  fetch not ready
- stallreq_id  in  1  load-use hazard
- stallreq_mem  in  1  data memory not ready
- mc_start  in  1  EX issues a multi-cycle op this cycle
- mc_is_div  in  1  with mc_start: 1 = divide, 0 = multiply
- excepttype  in  32  from MEM; 0 = none; 32'h0000000e = ERET
- cp0_epc  in  32  EPC value for ERET
- stall  out  6  per-stage hold: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb
- flush  out  1  clear all pipeline registers
- new_pc  out  32  redirect target, valid while flush = 1
- mc_busy  out  1  multi-cycle op in progress
- mc_done  out  1  one-cycle result-ready strobe to EX
- perf_stall_cycles  out  PERF_W  cycles with stall[0] = 1
- perf_mc_ops  out  PERF_W  completed multi-cycle ops

Behaviour:
- Reset (asynchronous, rst = 1): state IDLE, cnt = 0, perf counters = 0. Combinational outputs therefore read stall = 0, flush = 0, new_pc = 0, mc_busy = 0, mc_done = 0.
- FSM states: IDLE, MC_BUSY.
- IDLE, mc_start = 1, no exception: at the next edge load cnt = (mc_is_div ? DIV_CYCLES : MUL_CYCLES) - 1 and go to MC_BUSY.
- MC_BUSY: cnt decrements by 1 each edge. When cnt == 0 the next edge returns the FSM to IDLE.
- mc_busy = (state == MC_BUSY).
- mc_done = (state == MC_BUSY && cnt == 0), combinational.
- stall_mc = (state == IDLE && mc_start) || (state == MC_BUSY && cnt != 0).
- Net effect: exactly N stalled cycles (start cycle plus N-1 busy cycles), then one unstalled mc_done cycle.
- mc_start while in MC_BUSY is ignored.
- Stall masks, ORed together (they are nested, so the deepest request wins):
  - IF: 6'b000011
  - ID: 6'b000111
  - MC: 6'b001111
  - MEM: 6'b011111
- Exception (excepttype != 0) has highest priority:
  - flush = 1 and stall = 6'b000000 in the same cycle.
  - new_pc = cp0_epc if excepttype == 32'h0000000e, else EXC_VECTOR.
  - At the next edge, state is forced to IDLE and cnt to 0, aborting any MULT/DIV in flight.
  - No mc_done pulse for an aborted op.
- Exception and mc_start in the same cycle: the exception wins and the op is not started.
- flush, new_pc, stall and mc_done are combinational from state and inputs (zero latency). Only the FSM, cnt and perf counters are registered.
- Reset asserted mid-operation: immediate return to IDLE; no mc_done.

Optional Feature:
- Macro: STALL_PERF_EN.
- Defined:
  - perf_stall_cycles increments on each edge where stall[0] = 1.
  - perf_mc_ops increments on each edge where mc_done = 1.
  - Both saturate at all-ones and are cleared by reset only.
- Undefined: both outputs are tied to 0 and no counter flops are instantiated.

Decomposition:
- Shared define/package file holds:
  - stall mask constants
  - FSM state encodings
  - ERET excepttype code
  - existing Stop/NoStop, RstEnable and ZeroWord macros
- One natural sub-module: mc_seq_counter. It contains the FSM plus down-counter and outputs mc_busy, mc_done and stall_mc.
- Top level holds the mask OR, exception priority and perf counters.

Test Plan:
- Reset release, all inputs 0 -> stall = 6'b000000, flush = 0, mc_busy = 0, perf counters = 0.
- stallreq_id = 1 together with stallreq_if = 1 for one cycle -> stall = 6'b000111. Then stallreq_mem = 1 -> stall = 6'b011111.
- mc_start = 1, mc_is_div = 1 for one cycle -> stall = 6'b001111 for exactly 32 consecutive cycles, then mc_done = 1 for one cycle with stall = 0. With STALL_PERF_EN: perf_stall_cycles = 32, perf_mc_ops = 1.
- mc_start, mc_is_div = 0 -> 4 stall cycles, then mc_done. A second mc_start injected during MC_BUSY has no effect on cnt.
- Divide running (3rd busy cycle), excepttype = 32'h00000008 -> same cycle flush = 1, stall = 0, new_pc = 32'h00000020. Next cycle mc_busy = 0, and no mc_done ever follows.
- excepttype = 32'h0000000e with cp0_epc = 32'h00400010 -> flush = 1, new_pc = 32'h00400010. Asserting rst mid-divide -> mc_busy drops without waiting for a clock edge.
